// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. Each 32-bit instruction
//   accepted on the input handshake is classified by format (I/S/B/U/J, with
//   optional custom LH/SH and LUI/AUIPC). It is then presented one cycle later
//   with a sign-extended XLEN-wide immediate, a format code and an
//   illegal-opcode flag. A two-entry buffer (output register plus skid register)
//   keeps one instruction per cycle under back-pressure. in_ready depends only on
//   registered state.
//
// Parameters
//   XLEN     : immediate width, 32 or 64
//   EN_UTYPE : decode LUI/AUIPC as U-type (otherwise illegal)
//   EN_HALF  : decode custom LH (I-type) / SH (S-type) (otherwise illegal)
//   CNT_W    : width of the saturating delivered-instruction counter
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous discard of all buffered entries
//   in_valid / in_ready  : input handshake, in_instr is the instruction word
//   out_valid / out_ready: output handshake
//   out_instr            : instruction word, unchanged
//   out_imm              : sign-extended immediate
//   out_fmt              : 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_illegal          : opcode not recognised (or disabled)
//   dec_count            : saturating count of output handshakes
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit EN_UTYPE = 1'b1,
  parameter bit EN_HALF  = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LH    = 7'b0001011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SH    = 7'b0101011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  fmt_e        dec_fmt;
  logic        dec_illegal;
  logic [31:0] imm32;
  entry_t      dec;

  // NOTE: every variable written in an always_comb gets a default at the top,
  //       so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      OP_LH: begin
        if (EN_HALF) begin
          dec_fmt     = FMT_I;
          dec_illegal = 1'b0;
        end
      end
      OP_STORE: begin
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      OP_SH: begin
        if (EN_HALF) begin
          dec_fmt     = FMT_S;
          dec_illegal = 1'b0;
        end
      end
      OP_BR: begin
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        if (EN_UTYPE) begin
          dec_fmt     = FMT_U;
          dec_illegal = 1'b0;
        end
      end
      OP_JAL: begin
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
      OP_REG: begin
        // Legal, but carries no immediate.
        dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Immediates are assembled at 32 bits, then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.instr   = in_instr;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  entry_t            out_q, out_d;
  entry_t            skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_hs, out_hs;

  // Both handshakes are decoded from registered state only.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d = ST_ONE;
          out_d   = dec;
        end
      end
      ST_ONE: begin
        if (in_hs && out_hs) begin
          out_d = dec;
        end else if (in_hs) begin
          state_d = ST_FULL;
          skid_d  = dec;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_hs) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Data registers may load during a flush, but the EMPTY state hides them.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Saturating counter; a handshake in the flush cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset as well (not only the state) because
  //       out_* must read zero during reset; the skid register shares the
  //       reset for uniformity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_instr   = out_q.instr;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Four instances share one stimulus stream: default parameters, XLEN=64,
//   XLEN=64 with U-type and half-word opcodes disabled, and CNT_W=2. The
//   handshake behaviour is parameter-independent, so a single queue model
//   tracks all of them; a field-extraction decoder computes expected values.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_imm;
  logic [2:0]  out_fmt;
  logic [15:0] dec_count;

  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [31:0] r64_instr;
  logic [63:0] r64_imm;
  logic [2:0]  r64_fmt;
  logic [15:0] r64_cnt;

  logic        n64_in_ready, n64_out_valid, n64_ill;
  logic [31:0] n64_instr;
  logic [63:0] n64_imm;
  logic [2:0]  n64_fmt;
  logic [15:0] n64_cnt;

  logic        c2_in_ready, c2_out_valid, c2_ill;
  logic [31:0] c2_instr, c2_imm;
  logic [2:0]  c2_fmt;
  logic [1:0]  c2_cnt;

  imm_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .dec_count(dec_count)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_instr(r64_instr),
    .out_imm(r64_imm), .out_fmt(r64_fmt), .out_illegal(r64_ill),
    .dec_count(r64_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .EN_UTYPE(1'b0), .EN_HALF(1'b0)) dut64n (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n64_in_ready), .in_instr(in_instr),
    .out_valid(n64_out_valid), .out_ready(out_ready), .out_instr(n64_instr),
    .out_imm(n64_imm), .out_fmt(n64_fmt), .out_illegal(n64_ill),
    .dec_count(n64_cnt)
  );

  imm_gen_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c2_in_ready), .in_instr(in_instr),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_instr(c2_instr),
    .out_imm(c2_imm), .out_fmt(c2_fmt), .out_illegal(c2_ill),
    .dec_count(c2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queue of buffered instruction words plus counters.
  logic [31:0] mq[$];
  int          m_cnt;
  int          m_cnt2;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] r;
    r = v & ((64'd1 << bits) - 64'd1);
    if (r[bits-1]) r = r | (~64'd0 << bits);
    return r;
  endfunction

  // Reference decode built from the bit-field rules with shifts and masks.
  task automatic ref_dec(input logic [31:0] ins, input bit en_u, input bit en_h,
                         output logic [63:0] imm, output logic [2:0] fmt,
                         output logic ill);
    logic [63:0] w;
    w   = {32'd0, ins};
    fmt = 3'd0;
    ill = 1'b1;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 3'd1; ill = 1'b0; end
      7'h0B: if (en_h) begin fmt = 3'd1; ill = 1'b0; end
      7'h23: begin fmt = 3'd2; ill = 1'b0; end
      7'h2B: if (en_h) begin fmt = 3'd2; ill = 1'b0; end
      7'h63: begin fmt = 3'd3; ill = 1'b0; end
      7'h37, 7'h17: if (en_u) begin fmt = 3'd4; ill = 1'b0; end
      7'h6F: begin fmt = 3'd5; ill = 1'b0; end
      7'h33: ill = 1'b0;
      default: ;
    endcase
    case (fmt)
      3'd1: imm = sx(w >> 20, 12);
      3'd2: imm = sx(((w >> 25) << 5) | ((w >> 7) & 64'h1F), 12);
      3'd3: imm = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                     (((w >> 25) & 64'h3F) << 5) | (((w >> 8) & 64'hF) << 1), 13);
      3'd4: imm = sx(w & 64'hFFFF_F000, 32);
      3'd5: imm = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 64'hFF) << 12) |
                     (((w >> 20) & 1) << 11) | (((w >> 21) & 64'h3FF) << 1), 21);
      default: imm = 64'd0;
    endcase
  endtask

  task automatic compare_all();
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("dec_count", dec_count, m_cnt);
    check("dec_count_cnt2", c2_cnt, m_cnt2);
    check("valid_x64", r64_out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      ref_dec(mq[0], 1'b1, 1'b1, imm, fmt, ill);
      check("out_instr", out_instr, mq[0]);
      check("out_imm", out_imm, {32'd0, imm[31:0]});
      check("out_fmt", out_fmt, fmt);
      check("out_illegal", out_illegal, ill);
      check("imm_x64", r64_imm, imm);
      check("fmt_x64", r64_fmt, fmt);
      ref_dec(mq[0], 1'b0, 1'b0, imm, fmt, ill);
      check("imm_x64_nodis", n64_imm, imm);
      check("fmt_x64_nodis", n64_fmt, fmt);
      check("ill_x64_nodis", n64_ill, ill);
    end
  endtask

  // One clock: drive at negedge, advance the model, compare at next negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic fl, output logic acc);
    logic pre_ready, pre_valid;
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    pre_ready = (mq.size() < 2);
    pre_valid = (mq.size() > 0);
    #1;
    check("in_ready_no_comb_path", in_ready, pre_ready);
    acc = v && pre_ready && !fl;
    if (rdy && pre_valid) begin
      void'(mq.pop_front());
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (fl) mq.delete();
    else if (v && pre_ready) mq.push_back(ins);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_instr  = '0;
    mq.delete();
    m_cnt  = 0;
    m_cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t        tab[11];
  logic [31:0] words[4];
  logic [6:0]  ops[12];

  initial begin
    logic        acc;
    int          idx;
    int          saved;
    logic [31:0] w;

    tab[0]  = '{32'hFFF00093, 32'hFFFF_FFFF, 3'd1, 1'b0}; // ADDI -1
    tab[1]  = '{32'hFE000EE3, 32'hFFFF_FFFC, 3'd3, 1'b0}; // BEQ -4
    tab[2]  = '{32'h0080006F, 32'h0000_0008, 3'd5, 1'b0}; // JAL +8
    tab[3]  = '{32'h800000B7, 32'h8000_0000, 3'd4, 1'b0}; // LUI
    tab[4]  = '{32'h00112623, 32'h0000_000C, 3'd2, 1'b0}; // SW +12
    tab[5]  = '{32'h002081B3, 32'h0000_0000, 3'd0, 1'b0}; // ADD (R-type)
    tab[6]  = '{32'h0000007F, 32'h0000_0000, 3'd0, 1'b1}; // unknown opcode
    tab[7]  = '{32'h8000108B, 32'hFFFF_F800, 3'd1, 1'b0}; // custom LH
    tab[8]  = '{32'hFE00202B, 32'hFFFF_FFE0, 3'd2, 1'b0}; // custom SH
    tab[9]  = '{32'h00001017, 32'h0000_1000, 3'd4, 1'b0}; // AUIPC
    tab[10] = '{32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 1'b0}; // LW -4
    words   = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h00112623};
    ops     = '{7'h13, 7'h03, 7'h67, 7'h0B, 7'h23, 7'h2B, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

    // Reset values while rst_n is held low.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_instr = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_dec_count", dec_count, 64'd0);
    do_reset();

    // Directed table with out_ready held high: one result per cycle.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tab[i].instr, 1'b1, 1'b0, acc);
      check("tab_imm", out_imm, {32'd0, tab[i].imm});
      check("tab_fmt", out_fmt, tab[i].fmt);
      check("tab_illegal", out_illegal, tab[i].ill);
      check("tab_dec_count", dec_count, i);
      if (tab[i].instr == 32'h800000B7) begin
        check("lui_imm_x64", r64_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_imm_nou", n64_imm, 64'd0);
        check("lui_fmt_nou", n64_fmt, 3'd0);
        check("lui_ill_nou", n64_ill, 1'b1);
      end
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    check("tab_final_count", dec_count, 11);

    // Back-pressure: four words, out_ready low for the first six cycles.
    do_reset();
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(idx < 4, words[idx < 4 ? idx : 0], c >= 6, 1'b0, acc);
      if (acc) begin
        idx++;
        if (idx == 2) check("bp_in_ready_low", in_ready, 1'b0);
      end
    end
    check("bp_all_accepted", idx, 4);
    check("bp_dec_count", dec_count, 4);
    check("bp_cnt2_saturated", c2_cnt, 3);

    // Flush in FULL with a same-cycle input: the input word must never appear.
    do_reset();
    step(1'b1, 32'h00500113, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00A00193, 1'b0, 1'b0, acc);
    check("flush_setup_full", in_ready, 1'b0);
    saved = m_cnt;
    step(1'b1, 32'hDEADB0B7, 1'b0, 1'b1, acc);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_dec_count", dec_count, saved);
    for (int c = 0; c < 3; c++) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    check("flush_word_gone", out_valid, 1'b0);
    // Flush during an output handshake still counts the delivery.
    step(1'b1, 32'h00100093, 1'b1, 1'b0, acc);
    step(1'b0, 32'd0, 1'b1, 1'b1, acc);
    check("flush_counts_hs", dec_count, saved + 1);

    // Asynchronous reset between clock edges, with the buffer full.
    step(1'b1, 32'hFFF00093, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0080006F, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b1);
    check("async_out_instr", out_instr, 64'd0);
    check("async_out_imm", out_imm, 64'd0);
    check("async_out_fmt", out_fmt, 3'd0);
    check("async_out_illegal", out_illegal, 1'b0);
    check("async_dec_count", dec_count, 64'd0);
    mq.delete();
    m_cnt  = 0;
    m_cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0, acc);
    check("post_reset_accept", acc, 1'b1);

    // Randomised traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      w = $urandom();
      idx = $urandom_range(0, 11);
      if (idx < 11) w[6:0] = ops[idx];
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
